// File: rtl/calculator_8.sv
// calculator_8: registered 8-bit arithmetic unit.
// A multiply-accumulate datapath ({cout,prod} = a*b + cina + cinb) and an
// unsigned restoring divider (quo = a/b, rem = a%b) share operands a and b.
// Both results are computed combinationally and captured in a single
// register stage, giving one result set per accepted operand set.
module calculator_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] cina,
  input  logic [7:0] cinb,
  output logic       out_valid,
  output logic [7:0] prod,
  output logic [7:0] cout,
  output logic [7:0] quo,
  output logic [7:0] rem,
  output logic       div_by_zero
);

  localparam int DATA_W = 8;

  // Shift-add multiplier array. The two addends seed the accumulator as
  // carry-ins, so the row sum never exceeds 16'hFFFF.
  function automatic logic [2*DATA_W-1:0] mac_array(
    input logic [DATA_W-1:0] ma,
    input logic [DATA_W-1:0] mb,
    input logic [DATA_W-1:0] ca,
    input logic [DATA_W-1:0] cb
  );
    logic [2*DATA_W-1:0] acc;
    acc = {{DATA_W{1'b0}}, ca} + {{DATA_W{1'b0}}, cb};
    for (int i = 0; i < DATA_W; i++) begin
      if (mb[i]) begin
        acc = acc + ({{DATA_W{1'b0}}, ma} << i);
      end
    end
    return acc;
  endfunction

  // Eight-row restoring divider, MSB first. Returns {quotient, remainder}.
  // With a zero divisor every trial subtraction succeeds without removing
  // anything, which naturally yields quo=8'hFF and rem=a.
  function automatic logic [2*DATA_W-1:0] div_restoring(
    input logic [DATA_W-1:0] dn,
    input logic [DATA_W-1:0] dv
  );
    logic [DATA_W:0]   part;
    logic [DATA_W-1:0] q;
    part = '0;
    q    = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      part = {part[DATA_W-1:0], dn[i]};
      if (part >= {1'b0, dv}) begin
        part = part - {1'b0, dv};
        q[i] = 1'b1;
      end
    end
    return {q, part[DATA_W-1:0]};
  endfunction

  logic [2*DATA_W-1:0] mac_p0;
  logic [2*DATA_W-1:0] div_p0;
  logic                dbz_p0;

  // Stage p0: combinational results from the current operands
  always_comb begin
    mac_p0 = mac_array(a, b, cina, cinb);
    div_p0 = div_restoring(a, b);
    dbz_p0 = (b == '0);
  end

  logic              vld_p1;
  logic [DATA_W-1:0] prod_p1;
  logic [DATA_W-1:0] cout_p1;
  logic [DATA_W-1:0] quo_p1;
  logic [DATA_W-1:0] rem_p1;
  logic              dbz_p1;

  // Stage p1: result registers; capture on in_valid, hold otherwise, clear on rst
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
      cout_p1 <= '0;
      quo_p1  <= '0;
      rem_p1  <= '0;
      dbz_p1  <= 1'b0;
    end else if (in_valid) begin
      vld_p1  <= 1'b1;
      prod_p1 <= mac_p0[DATA_W-1:0];
      cout_p1 <= mac_p0[2*DATA_W-1:DATA_W];
      quo_p1  <= div_p0[2*DATA_W-1:DATA_W];
      rem_p1  <= div_p0[DATA_W-1:0];
      dbz_p1  <= dbz_p0;
    end else begin
      vld_p1  <= 1'b0;
      prod_p1 <= prod_p1;
      cout_p1 <= cout_p1;
      quo_p1  <= quo_p1;
      rem_p1  <= rem_p1;
      dbz_p1  <= dbz_p1;
    end
  end

  assign out_valid   = vld_p1;
  assign prod        = prod_p1;
  assign cout        = cout_p1;
  assign quo         = quo_p1;
  assign rem         = rem_p1;
  assign div_by_zero = dbz_p1;

endmodule

// File: tb/tb_calculator_8.sv
// Testbench for calculator_8: directed vector table, hand-written reset/hold
// sequences, and a randomized stream checked against a behavioural model.
module tb_calculator_8;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b, cina, cinb;
  logic       out_valid;
  logic [7:0] prod, cout, quo, rem;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  calculator_8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .cina(cina), .cinb(cinb),
    .out_valid(out_valid), .prod(prod), .cout(cout),
    .quo(quo), .rem(rem), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output state of the model
  logic       e_vld;
  logic [7:0] e_prod, e_cout, e_quo, e_rem;
  logic       e_dbz;

  typedef struct {
    logic [7:0] a, b, ca, cb;
    logic [7:0] prod, cout, quo, rem;
    logic       dbz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: plain arithmetic on the applied operands
  task automatic model(input logic r, input logic v,
                       input logic [7:0] ia, ib, ic, id);
    int full;
    if (r) begin
      e_vld = 0; e_prod = 0; e_cout = 0; e_quo = 0; e_rem = 0; e_dbz = 0;
    end else if (v) begin
      full   = int'(ia) * int'(ib) + int'(ic) + int'(id);
      e_vld  = 1;
      e_prod = full[7:0];
      e_cout = full[15:8];
      if (ib == 0) begin
        e_quo = 8'hFF; e_rem = ia; e_dbz = 1;
      end else begin
        e_quo = 8'(int'(ia) / int'(ib));
        e_rem = 8'(int'(ia) % int'(ib));
        e_dbz = 0;
      end
    end else begin
      e_vld = 0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic cycle(input logic r, input logic v,
                       input logic [7:0] ia, ib, ic, id);
    rst = r; in_valid = v; a = ia; b = ib; cina = ic; cinb = id;
    model(r, v, ia, ib, ic, id);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, out_valid, e_vld);
    chk({tag, ".prod"}, prod, e_prod);
    chk({tag, ".cout"}, cout, e_cout);
    chk({tag, ".quo"}, quo, e_quo);
    chk({tag, ".rem"}, rem, e_rem);
    chk({tag, ".dbz"}, div_by_zero, e_dbz);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".prod"}, prod, 0);
    chk({tag, ".cout"}, cout, 0);
    chk({tag, ".quo"}, quo, 0);
    chk({tag, ".rem"}, rem, 0);
    chk({tag, ".dbz"}, div_by_zero, 0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [7:0] ra, rb, rc, rd;
    vecs[0] = '{8'd200, 8'd100, 8'd50,  8'd30, 8'h70, 8'h4E, 8'd2,   8'd0,   1'b0};
    vecs[1] = '{8'hFF,  8'hFF,  8'hFF,  8'hFF, 8'hFF, 8'hFF, 8'd1,   8'd0,   1'b0};
    vecs[2] = '{8'd200, 8'd7,   8'd0,   8'd0,  8'h78, 8'h05, 8'd28,  8'd4,   1'b0};
    vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd0,  8'h2D, 8'h00, 8'd0,   8'd5,   1'b0};
    vecs[4] = '{8'd123, 8'd0,   8'd1,   8'd2,  8'h03, 8'h00, 8'hFF,  8'd123, 1'b1};
    vecs[5] = '{8'd0,   8'd13,  8'd7,   8'd0,  8'h07, 8'h00, 8'd0,   8'd0,   1'b0};
    vecs[6] = '{8'd77,  8'd1,   8'd0,   8'd0,  8'h4D, 8'h00, 8'd77,  8'd0,   1'b0};
    vecs[7] = '{8'd255, 8'd16,  8'd1,   8'd1,  8'hF2, 8'h0F, 8'd15,  8'd15,  1'b0};
    vecs[8] = '{8'd0,   8'd0,   8'd0,   8'd0,  8'h00, 8'h00, 8'hFF,  8'd0,   1'b1};

    rst = 1; in_valid = 0; a = 0; b = 0; cina = 0; cinb = 0;

    // Reset held two cycles, then released with in_valid low
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 8'd9, 8'd3, 8'd1, 8'd1);
    check_zero("reset");
    cycle(0, 0, 8'd9, 8'd3, 8'd1, 8'd1);
    check_zero("post_reset_idle");

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, vecs[i].a, vecs[i].b, vecs[i].ca, vecs[i].cb);
      chk($sformatf("vec%0d.out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d.prod", i), prod, vecs[i].prod);
      chk($sformatf("vec%0d.cout", i), cout, vecs[i].cout);
      chk($sformatf("vec%0d.quo", i), quo, vecs[i].quo);
      chk($sformatf("vec%0d.rem", i), rem, vecs[i].rem);
      chk($sformatf("vec%0d.dbz", i), div_by_zero, vecs[i].dbz);
    end

    // Hold: in_valid low drops out_valid but keeps the last results
    cycle(0, 1, 8'd200, 8'd7, 8'd0, 8'd0);
    cycle(0, 0, 8'd1, 8'd1, 8'd1, 8'd1);
    chk("hold.out_valid", out_valid, 0);
    chk("hold.quo", quo, 28);
    chk("hold.rem", rem, 4);
    chk("hold.prod", prod, 8'h78);
    cycle(0, 0, 8'd3, 8'd2, 8'd0, 8'd0);
    check_model("hold2");

    // Reset discards an operation presented in the same cycle
    cycle(1, 1, 8'd50, 8'd5, 8'd5, 8'd5);
    check_zero("rst_priority");

    // Random streaming with a single reset pulse mid-run
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
      if (n % 50 == 7) rb = 8'd0;
      if (n == 500) begin
        cycle(1, 1, ra, rb, rc, rd);
        check_zero("stream_rst");
      end else begin
        cycle(0, 1, ra, rb, rc, rd);
        check_model($sformatf("stream%0d", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
